// File: rtl/freq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_div_pkg
// Description : Shared constants and helpers for the multi-channel divider.
//               DIV_MIN  - smallest divisor a channel will ever run with.
//               clamp_div - raises any divisor below DIV_MIN up to DIV_MIN.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    // Operates on a 32-bit container so one function serves every divisor
    // width; callers zero-extend their W-bit value in and cast the result back.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_divider_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : freq_divider_multi_if
// Description : Control/status bundle of the multi-channel divider.
//               en   [CH]   per-channel enable
//               div  [CH*W] divisors, channel i at div[i*W +: W]
//               load [CH]   per-channel divisor capture strobe
//               fout [CH]   divided clocks
//               tick [CH]   end-of-period pulses
//               master: drives en/div/load; slave: the divider itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface freq_divider_multi_if #(
    parameter int CH = 2,
    parameter int W  = 4
);
    logic [CH-1:0]   en;
    logic [CH*W-1:0] div;
    logic [CH-1:0]   load;
    logic [CH-1:0]   fout;
    logic [CH-1:0]   tick;

    modport master (output en, div, load, input  fout, tick);
    modport slave  (input  en, div, load, output fout, tick);
endinterface
`default_nettype wire

// File: rtl/freq_div_channel.sv
`default_nettype none
// ============================================================================
// Module      : freq_div_channel
// Description : One integer divider channel with double-buffered divisor.
//               fin  in  source clock
//               rst  in  asynchronous active-high reset
//               en   in  channel enable (low holds the channel idle)
//               div  in  W-bit divisor candidate
//               load in  captures div into the shadow register
//               fout out divided clock
//               tick out pulse in the last fin cycle of each period
//               Optional macro ODD_DUTY50_EN adds a negedge stage giving
//               exact 50% duty on odd divisors.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int W       = 4,
    parameter int DIV_RST = 2
) (
    input  wire logic         fin,
    input  wire logic         rst,
    input  wire logic         en,
    input  wire logic [W-1:0] div,
    input  wire logic         load,
    output logic              fout,
    output logic              tick
);

    localparam logic [W-1:0] c_ONE     = W'(1);
    localparam logic [W-1:0] c_DIV_RST = W'(DIV_RST);

    logic [W-1:0] r_count;
    logic [W-1:0] r_shadow;
    logic [W-1:0] r_act;
    logic         r_fpos;
    logic         r_tick;

    logic [W-1:0] w_div_clamped;
    logic [W-1:0] w_next_act;
    logic         w_wrap;

    assign w_div_clamped = W'(clamp_div(32'(div)));
    // A load arriving on the same edge as the period boundary bypasses the
    // shadow so the new divisor takes effect for the very next period.
    assign w_next_act    = load ? w_div_clamped : r_shadow;
    assign w_wrap        = (r_count >= r_act);

    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            r_count  <= c_ONE;
            r_shadow <= c_DIV_RST;
            r_act    <= c_DIV_RST;
            r_fpos   <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= w_div_clamped;
            end
            if (!en) begin
                r_count <= c_ONE;
                r_fpos  <= 1'b0;
                r_tick  <= 1'b0;
                r_act   <= w_next_act;
            end else begin
                r_count <= w_wrap ? c_ONE : (r_count + c_ONE);
                r_fpos  <= (r_count <= (r_act >> 1));
                r_tick  <= w_wrap;
                if (w_wrap) begin
                    r_act <= w_next_act;
                end
            end
        end
    end

`ifdef ODD_DUTY50_EN
    // Half-cycle delayed copy of fpos stretches the high phase by half a fin
    // period on odd divisors; fpos is already low whenever en is low, so this
    // stage clears itself one half-cycle later.
    logic r_fneg;

    always_ff @(negedge fin or posedge rst) begin
        if (rst) begin
            r_fneg <= 1'b0;
        end else begin
            r_fneg <= r_fpos;
        end
    end

    assign fout = r_fpos | (r_act[0] & r_fneg);
`else
    assign fout = r_fpos;
`endif

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/freq_divider_multi.sv
`default_nettype none
// ============================================================================
// Module      : freq_divider_multi
// Description : CH independent programmable integer clock dividers.
//               fin in  source clock
//               rst in  asynchronous active-high reset
//               bus slave modport of freq_divider_multi_if
//                   (en, div, load in; fout, tick out)
//               Optional macro ODD_DUTY50_EN: 50% duty on odd divisors.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_divider_multi #(
    parameter int CH      = 2,
    parameter int W       = 4,
    parameter int DIV_RST = 2
) (
    input  wire logic            fin,
    input  wire logic            rst,
    freq_divider_multi_if.slave  bus
);

    logic [CH-1:0] w_fout;
    logic [CH-1:0] w_tick;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        freq_div_channel #(
            .W       (W),
            .DIV_RST (DIV_RST)
        ) u_channel (
            .fin  (fin),
            .rst  (rst),
            .en   (bus.en[i]),
            .div  (bus.div[i*W +: W]),
            .load (bus.load[i]),
            .fout (w_fout[i]),
            .tick (w_tick[i])
        );
    end

    assign bus.fout = w_fout;
    assign bus.tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_freq_divider_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_divider_multi
// Description : Directed self-checking bench for freq_divider_multi
//               (CH=2, W=4, DIV_RST=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_divider_multi;

    localparam int c_CH = 2;
    localparam int c_W  = 4;

    logic fin;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   hi_cnt;

    freq_divider_multi_if #(.CH(c_CH), .W(c_W)) bus ();

    freq_divider_multi #(
        .CH      (c_CH),
        .W       (c_W),
        .DIV_RST (2)
    ) u_dut (
        .fin (fin),
        .rst (rst),
        .bus (bus)
    );

    initial fin = 1'b0;
    always #5 fin = ~fin;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge fin);
        #1;
    endtask

    task automatic load_ch(input int ch, input logic [3:0] val);
        bus.div[ch*c_W +: c_W] = val;
        bus.load[ch] = 1'b1;
        clk_step();
        bus.load[ch] = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.en   = '0;
        bus.div  = '0;
        bus.load = '0;
        clk_step();
        clk_step();
        check_eq("reset_fout", 32'(bus.fout), 32'd0);
        check_eq("reset_tick", 32'(bus.tick), 32'd0);

        // ---- test 1: N=DIV_RST=2 toggles, async reset mid high phase
        rst       = 1'b0;
        bus.en[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            clk_step();
            check_eq("t1_n2", 32'({bus.fout[0], bus.tick[0]}),
                     (k % 2 == 1) ? 32'b10 : 32'b01);
        end
        clk_step();
        check_eq("t1_pre_rst_fout", 32'(bus.fout[0]), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t1_async_rst", 32'({bus.fout, bus.tick}), 32'd0);
        clk_step();
        rst = 1'b0;
        clk_step();
        check_eq("t1_after_rst_hi", 32'(bus.fout[0]), 32'd1);
        clk_step();
        check_eq("t1_after_rst_lo", 32'({bus.fout[0], bus.tick[0]}), 32'b01);
        bus.en[0] = 1'b0;
        clk_step();

        // ---- test 2: N=6, 3 high / 3 low, tick in cycles 6,12,18
        load_ch(0, 4'd6);
        bus.en[0] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            clk_step();
            check_eq("t2_n6", 32'({bus.fout[0], bus.tick[0]}),
                     {30'd0, ((k - 1) % 6) < 3, (k % 6) == 0});
        end
        bus.en[0] = 1'b0;
        clk_step();

        // ---- test 3: N=4 running, load 7 at count=2
        load_ch(0, 4'd4);
        bus.en[0] = 1'b1;
        clk_step();                                 // k=1, count now 2
        check_eq("t3_k1", 32'(bus.fout[0]), 32'd1);
        load_ch(0, 4'd7);                           // k=2
        check_eq("t3_k2", 32'(bus.fout[0]), 32'd1);
        clk_step();                                 // k=3
        check_eq("t3_k3", 32'({bus.fout[0], bus.tick[0]}), 32'b00);
        clk_step();                                 // k=4, end of N=4 period
        check_eq("t3_k4", 32'({bus.fout[0], bus.tick[0]}), 32'b01);
        hi_cnt = 0;
        for (int j = 0; j < 7; j++) begin
            clk_step();
            if (bus.fout[0]) hi_cnt++;
            if (j == 0) check_eq("t3_n7_start", 32'(bus.fout[0]), 32'd1);
            if (j >= 5) check_eq("t3_n7_tick", 32'(bus.tick[0]), (j == 6) ? 32'd1 : 32'd0);
            @(negedge fin);
            #1;
            if (bus.fout[0]) hi_cnt++;
        end
`ifdef ODD_DUTY50_EN
        check_eq("t3_n7_high_halves", 32'(hi_cnt), 32'd7);
`else
        check_eq("t3_n7_high_halves", 32'(hi_cnt), 32'd6);
`endif

        // ---- test 4: load div=5 on the wrap edge of the N=7 period
        for (int j = 0; j < 6; j++) clk_step();
        load_ch(0, 4'd5);
        check_eq("t4_wrap_tick", 32'(bus.tick[0]), 32'd1);
        for (int m = 1; m <= 10; m++) begin
            clk_step();
            check_eq("t4_n5_tick", 32'(bus.tick[0]), (m % 5 == 0) ? 32'd1 : 32'd0);
        end
        // div=0 clamps to 2
        bus.en[0] = 1'b0;
        clk_step();
        load_ch(0, 4'd0);
        bus.en[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            clk_step();
            check_eq("t4_clamp_n2", 32'({bus.fout[0], bus.tick[0]}),
                     (k % 2 == 1) ? 32'b10 : 32'b01);
        end

        // ---- test 5: N=8, drop en during high phase, re-enable
        bus.en[0] = 1'b0;
        clk_step();
        load_ch(0, 4'd8);
        bus.en[0] = 1'b1;
        clk_step();
        clk_step();
        check_eq("t5_high_before_drop", 32'(bus.fout[0]), 32'd1);
        bus.en[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clk_step();
            check_eq("t5_held_low", 32'({bus.fout[0], bus.tick[0]}), 32'd0);
        end
        bus.en[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            clk_step();
            check_eq("t5_n8", 32'({bus.fout[0], bus.tick[0]}),
                     {30'd0, ((k - 1) % 8) < 4, (k % 8) == 0});
        end

        // ---- test 6: ch0 N=3, ch1 N=10, loaded on the same cycle
        bus.en = '0;
        clk_step();
        bus.div  = {4'd10, 4'd3};
        bus.load = 2'b11;
        clk_step();
        bus.load = 2'b00;
        bus.en   = 2'b11;
        for (int k = 1; k <= 30; k++) begin
            clk_step();
            check_eq("t6_two_ch", 32'({bus.fout[1], bus.tick[1], bus.fout[0], bus.tick[0]}),
                     {28'd0, ((k - 1) % 10) < 5, (k % 10) == 0,
`ifdef ODD_DUTY50_EN
                      ((k - 1) % 3) <= 1,
`else
                      ((k - 1) % 3) == 0,
`endif
                      (k % 3) == 0});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
